serial_adder: RTL and testbench

- Parametrised bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop.
- Start/busy/done handshake.
- Sits as the sequential, area-minimal companion to the combinational gate and adder primitives in the arithmetic library.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/full_adder_cell.sv | 15 +
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

   // Two-state control: waiting for a request, or shifting bits through the cell.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1
   } state_t;

   // Bit counter must hold values 0..width, so it needs clog2(width+1) bits.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: single-bit combinational full adder, the only arithmetic in
// the serial adder datapath.
module full_adder_cell (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   // Sum is the parity of the three inputs; carry is their majority.
   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
// through one full_adder_cell and a carry flip-flop. Start/busy/done handshake.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the
// operation into a - b (b inverted, initial carry 1; carry_out=1 means no borrow).
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             fa_s;
   logic             fa_cout;
   logic [WIDTH-1:0] sum_sr_next;
   logic             sub_eff;

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_eff = sub;
`else
   assign sub_eff = 1'b0;
`endif

   // One shared cell processes the current LSBs with the running carry.
   full_adder_cell u_fa (
      .x    (a_sr[0]),
      .y    (b_sr[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // New sum bit enters at the MSB; after WIDTH shifts the LSB lands at bit 0.
   // The concatenation form stays legal when WIDTH is 1.
   logic [WIDTH:0] sum_shift;
   assign sum_shift   = {fa_s, sum_sr};
   assign sum_sr_next = sum_shift[WIDTH:1];

   // Control FSM and datapath registers, all with registered outputs.
   // NOTE: every register here uses <= so all updates see pre-edge values;
   // the datapath registers are reset too so an aborted operation leaves
   // nothing stale behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a_sr      <= '0;
         b_sr      <= '0;
         sum_sr    <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= sub_eff ? ~b : b;
                  sum_sr <= '0;
                  carry  <= sub_eff;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_sr_next;
               carry  <= fa_cout;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  sum       <= sum_sr_next;
                  carry_out <= fa_cout;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8) plus an
// exhaustive check of full_adder_cell. Define SERIAL_ADDER_SUB_EN to also
// exercise subtraction.
module tb_serial_adder;

   localparam int WIDTH = 8;
   localparam int LAT   = WIDTH + 1;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             sub = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;

   logic fx, fy, fc, fs, fco;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   done_count = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
`ifdef SERIAL_ADDER_SUB_EN
      .sub       (sub),
`endif
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out)
   );

   full_adder_cell u_fa_ut (
      .x    (fx),
      .y    (fy),
      .cin  (fc),
      .s    (fs),
      .cout (fco)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent reference: plain integer add / subtract.
   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic s);
      exp_t e;
      logic [WIDTH:0] t;
      if (s) begin
         e.sum  = x - y;
         e.cout = (x >= y);
      end else begin
         t      = {1'b0, x} + {1'b0, y};
         e.sum  = t[WIDTH-1:0];
         e.cout = t[WIDTH];
      end
      return e;
   endfunction

   // Monitor: every done pulse pops and compares one expected result.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         done_count++;
         if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            e = sb.pop_front();
            check("sum", sum, e.sum);
            check("carry_out", carry_out, e.cout);
         end
      end
   end

   // Called right after the start edge; returns the sample index where done is seen.
   task automatic wait_done(output int n, output int busy_cnt);
      n = 1;
      busy_cnt = 0;
      while (!done && n <= 40) begin
         if (busy) busy_cnt++;
         tick();
         n++;
      end
      if (!done) check("done_timeout", 0, 1);
   endtask

   task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
      int n, bc;
      a = x;
      b = y;
      sub = s;
      start = 1'b1;
      sb.push_back(model(x, y, s));
      tick();
      start = 1'b0;
      check("busy_after_start", busy, 1);
      wait_done(n, bc);
      check("latency", n, LAT);
      check("busy_cycles", bc, WIDTH);
      check("busy_in_done", busy, 0);
      tick();
      check("done_one_cycle", done, 0);
      check("sum_held", sum, model(x, y, s).sum);
   endtask

   initial begin : main
      int n, bc, dc;

      #1000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int n, bc, dc;

      // Full adder cell: all eight input combinations.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         int ones;
         v = i[2:0];
         {fx, fy, fc} = v;
         #1;
         ones = int'(fx) + int'(fy) + int'(fc);
         check("fa_s", fs, ones % 2);
         check("fa_cout", fco, ones >= 2);
      end

      // Reset state.
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", carry_out, 0);

      // Basic operations.
      run_op(8'h0F, 8'h01, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0);
      run_op(8'hA5, 8'h5A, 1'b0);

      // Start during RUN is ignored.
      dc = done_count;
      a = 8'h3C;
      b = 8'h21;
      start = 1'b1;
      sb.push_back(model(8'h3C, 8'h21, 1'b0));
      tick();
      start = 1'b0;
      tick();
      tick();
      a = 8'h00;
      b = 8'h00;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      check("ignore_one_done", done_count - dc, 1);
      check("ignore_sum", sum, 8'h5D);

      // Reset aborts a running operation.
      dc = done_count;
      a = 8'h80;
      b = 8'h80;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_sum", sum, 0);
      check("abort_cout", carry_out, 0);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      check("abort_no_done", done_count - dc, 0);

      // Reset wins over start.
      rst = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      tick();
      check("rst_beats_start", busy, 0);

      run_op(8'h80, 8'h80, 1'b0);

      // Start held high: back-to-back operations WIDTH+1 cycles apart.
      a = 8'h01;
      b = 8'h02;
      sub = 1'b0;
      start = 1'b1;
      sb.push_back(model(8'h01, 8'h02, 1'b0));
      tick();
      wait_done(n, bc);
      check("b2b_first_latency", n, LAT);
      a = 8'h10;
      b = 8'h20;
      sb.push_back(model(8'h10, 8'h20, 1'b0));
      tick();
      check("b2b_done_drops", done, 0);
      check("b2b_busy_rises", busy, 1);
      wait_done(n, bc);
      start = 1'b0;
      check("b2b_spacing", n, LAT);
      check("b2b_sum", sum, 8'h30);
      tick();

      // Random additions.
      for (int i = 0; i < 6; i++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'b0);
      end

`ifdef SERIAL_ADDER_SUB_EN
      run_op(8'd5, 8'd3, 1'b1);
      check("sub_5_3", sum, 8'h02);
      run_op(8'd3, 8'd5, 1'b1);
      check("sub_3_5", sum, 8'hFE);
      run_op(8'd7, 8'd7, 1'b1);
      run_op(8'd9, 8'd4, 1'b0);
`endif

      tick();
      check("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
